// File: rtl/sys_app_mem.sv
// sys_app_mem: BRAM-backed responder for the 128-bit app_* memory interface; SYS_APP_MEM_OOR_CHECK_EN enables range checking.
// Latency: writes commit at the accepting edge; read data is valid RD_LATENCY cycles after the accepting edge.
// Backpressure: app_rdy drops while a write command waits for its beat; app_wdf_rdy drops while a beat is buffered.
module sys_app_mem #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [27:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    output logic         app_rdy,
    input  logic [127:0] app_wdf_data,
    input  logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         oor_err
);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam int         DEPTH  = 1 << ADDR_W;

    typedef enum logic {IDLE, WAIT_WDATA} state_t;

    state_t              state;
    logic [127:0]        mem [DEPTH];

    logic [127:0]        buf_dat;
    logic [15:0]         buf_mask;
    logic                buf_vld;
    logic                buf_vld_nxt;
    logic [ADDR_W-1:0]   lat_idx;
    logic                lat_oor;

    logic                cmd_acc;
    logic                beat_acc;
    logic                wr_cmd;
    logic                rd_cmd;
    logic [ADDR_W-1:0]   cmd_idx;
    logic                cmd_oor;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic [127:0]        wr_dat;
    logic [15:0]         wr_mask;
    logic                buf_load;
    logic                buf_drain;
    logic                go_wait;
    logic                wait_done;

    logic [RD_LATENCY-1:0] rd_vld_pipe;
    logic [127:0]          rd_dat_pipe [RD_LATENCY];

    logic                unused_in;

    assign cmd_acc  = app_en && app_rdy;
    assign beat_acc = app_wdf_wren && app_wdf_rdy;
    assign wr_cmd   = cmd_acc && (app_cmd == CMD_WR);
    assign rd_cmd   = cmd_acc && (app_cmd == CMD_RD);
    assign cmd_idx  = app_addr[ADDR_W-1:0];

    // Every beat is a complete transfer, so the end marker carries no information.
    assign unused_in = ^{app_addr[27:ADDR_W], app_wdf_end};

`ifdef SYS_APP_MEM_OOR_CHECK_EN
    assign cmd_oor = |app_addr[27:ADDR_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oor_err <= 1'b0;
        end else if ((wr_cmd || rd_cmd) && cmd_oor) begin
            oor_err <= 1'b1;
        end
    end
`else
    assign cmd_oor = 1'b0;
    assign oor_err = 1'b0;
`endif

    // Pick the single write source for this edge: waiting command, buffered beat, or same-cycle beat.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = cmd_idx;
        wr_dat    = app_wdf_data;
        wr_mask   = app_wdf_mask;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        go_wait   = 1'b0;
        wait_done = 1'b0;
        if (state == WAIT_WDATA) begin
            if (beat_acc) begin
                wr_en     = !lat_oor;
                wr_idx    = lat_idx;
                wait_done = 1'b1;
            end
        end else if (wr_cmd) begin
            if (buf_vld) begin
                wr_en     = !cmd_oor;
                wr_dat    = buf_dat;
                wr_mask   = buf_mask;
                buf_drain = 1'b1;
            end else if (beat_acc) begin
                wr_en     = !cmd_oor;
            end else begin
                go_wait   = 1'b1;
            end
        end else if (beat_acc) begin
            buf_load = 1'b1;
        end
    end

    assign buf_vld_nxt = buf_load || (buf_vld && !buf_drain);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 16; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            app_rdy     <= 1'b0;
            app_wdf_rdy <= 1'b0;
            buf_vld     <= 1'b0;
            buf_dat     <= '0;
            buf_mask    <= '0;
            lat_idx     <= '0;
            lat_oor     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_wait) begin
                        state   <= WAIT_WDATA;
                        lat_idx <= cmd_idx;
                        lat_oor <= cmd_oor;
                    end
                end
                WAIT_WDATA: begin
                    if (wait_done) begin
                        state   <= IDLE;
                        lat_idx <= '0;
                        lat_oor <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            app_rdy     <= (state == IDLE) ? !go_wait : wait_done;
            app_wdf_rdy <= !buf_vld_nxt;

            if (buf_load) begin
                buf_vld  <= 1'b1;
                buf_dat  <= app_wdf_data;
                buf_mask <= app_wdf_mask;
            end else if (buf_drain) begin
                buf_vld  <= 1'b0;
            end
        end
    end

    // Data stages only advance behind a valid token, so the output holds its last read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_dat_pipe[i] <= '0;
            end
        end else begin
            rd_vld_pipe[0] <= rd_cmd;
            if (rd_cmd) begin
                rd_dat_pipe[0] <= cmd_oor ? '0 : mem[cmd_idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_pipe[i] <= rd_vld_pipe[i-1];
                if (rd_vld_pipe[i-1]) begin
                    rd_dat_pipe[i] <= rd_dat_pipe[i-1];
                end
            end
        end
    end

    assign app_rd_data_valid = rd_vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_pipe[RD_LATENCY-1];
    assign app_rd_data       = rd_dat_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_sys_app_mem.sv
// Bench for sys_app_mem: directed vectors, a queue-based reference model checked every cycle,
// and literal expectations for each scenario.
module tb_sys_app_mem;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
`ifdef SYS_APP_MEM_OOR_CHECK_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'h0123456789ABCDEF0123456789ABCDAA;
    localparam logic [127:0] D0 = 128'hFEDCBA98765432100011223344556677;
    localparam logic [127:0] DX = {4{32'hDEADBEEF}};

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [27:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         oor_err;

    sys_app_mem #(.ADDR_W(ADDR_W), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pending write commands and beats pair up in order and commit when both exist.
    typedef struct packed { int due; logic [127:0] dat; logic chk; } rsp_t;
    typedef struct packed { int idx; logic oor; } wcmd_t;
    typedef struct packed { logic [127:0] dat; logic [15:0] mask; } beat_t;

    rsp_t         rq[$];
    wcmd_t        cq[$];
    beat_t        bq[$];
    logic [127:0] mdl_mem [int];
    bit           active = 1'b0;
    bit           mdl_oor = 1'b0;
    logic [127:0] last_rd = '0;
    int           cyc = 0;

    always @(negedge clk) begin : mon
        rsp_t r;
        wcmd_t c;
        beat_t b;
        logic e_rdy, e_wrdy, e_vld, cacc, bacc, oor;
        logic [127:0] w;
        int idx;
        if (!resetn) begin
            check_b("rst_app_rdy", app_rdy, 1'b0);
            check_b("rst_wdf_rdy", app_wdf_rdy, 1'b0);
            check_b("rst_rd_valid", app_rd_data_valid, 1'b0);
            check_b("rst_rd_end", app_rd_data_end, 1'b0);
            check_w("rst_rd_data", app_rd_data, '0);
            check_b("rst_oor_err", oor_err, 1'b0);
            rq.delete(); cq.delete(); bq.delete(); mdl_mem.delete();
            active = 1'b0; mdl_oor = 1'b0; last_rd = '0;
        end else begin
            e_rdy  = active && (cq.size() == 0);
            e_wrdy = active && (bq.size() == 0);
            e_vld  = (rq.size() > 0) && (rq[0].due == cyc);
            check_b("app_rdy", app_rdy, e_rdy);
            check_b("app_wdf_rdy", app_wdf_rdy, e_wrdy);
            check_b("oor_err", oor_err, mdl_oor);
            check_b("rd_valid", app_rd_data_valid, e_vld);
            check_b("rd_end", app_rd_data_end, e_vld);
            if (e_vld) begin
                r = rq.pop_front();
                if (r.chk) begin
                    last_rd = r.dat;
                    check_w("rd_data", app_rd_data, r.dat);
                end else begin
                    last_rd = app_rd_data;
                end
            end else begin
                check_w("rd_hold", app_rd_data, last_rd);
            end

            cacc = app_en && e_rdy;
            bacc = app_wdf_wren && e_wrdy;
            idx  = int'(app_addr) % (1 << ADDR_W);
            oor  = OOR_EN && (int'(app_addr) >= (1 << ADDR_W));
            if (cacc && app_cmd == 3'b001) begin
                r.due = cyc + RD_LAT;
                if (oor) begin
                    r.dat = '0; r.chk = 1'b1;
                end else if (mdl_mem.exists(idx)) begin
                    r.dat = mdl_mem[idx]; r.chk = 1'b1;
                end else begin
                    r.dat = '0; r.chk = 1'b0;
                end
                rq.push_back(r);
                if (oor) mdl_oor = 1'b1;
            end
            if (cacc && app_cmd == 3'b000) begin
                c.idx = idx; c.oor = oor;
                cq.push_back(c);
                if (oor) mdl_oor = 1'b1;
            end
            if (bacc) begin
                b.dat = app_wdf_data; b.mask = app_wdf_mask;
                bq.push_back(b);
            end
            if (cq.size() > 0 && bq.size() > 0) begin
                c = cq.pop_front();
                b = bq.pop_front();
                if (!c.oor) begin
                    w = mdl_mem.exists(c.idx) ? mdl_mem[c.idx] : '0;
                    for (int i = 0; i < 16; i++) begin
                        if (b.mask[i]) w[8*i +: 8] = b.dat[8*i +: 8];
                    end
                    mdl_mem[c.idx] = w;
                end
            end
            active = 1'b1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [27:0] a, input string name);
        app_en = 1'b1; app_cmd = c; app_addr = a;
        for (int n = 0; n < 20 && !app_rdy; n++) tick();
        check_b({name, "_rdy_wait"}, app_rdy, 1'b1);
        tick();
        app_en = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [15:0] m, input string name);
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
        for (int n = 0; n < 20 && !app_wdf_rdy; n++) tick();
        check_b({name, "_wdf_rdy_wait"}, app_wdf_rdy, 1'b1);
        tick();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic write_now(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m, input string name);
        app_en = 1'b1; app_cmd = 3'b000; app_addr = a;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
        for (int n = 0; n < 20 && !(app_rdy && app_wdf_rdy); n++) tick();
        check_b({name, "_both_rdy"}, app_rdy && app_wdf_rdy, 1'b1);
        tick();
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic read_chk(input logic [27:0] a, input logic [127:0] exp, input string name);
        int n;
        bit seen;
        issue(3'b001, a, name);
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = app_rd_data_valid;
        end
        check_b({name, "_seen"}, seen, 1'b1);
        check_i({name, "_latency"}, n, RD_LAT);
        check_w({name, "_data"}, app_rd_data, exp);
        check_b({name, "_end"}, app_rd_data_end, 1'b1);
        tick();
    endtask

    initial begin : drv
        int cnt;
        #1 resetn = 1'b0;
        repeat (3) tick();
        check_b("rst_app_rdy_low", app_rdy, 1'b0);
        check_b("rst_wdf_rdy_low", app_wdf_rdy, 1'b0);
        resetn = 1'b1;
        check_b("rel_app_rdy_before_edge", app_rdy, 1'b0);
        tick();
        check_b("rel_app_rdy", app_rdy, 1'b1);
        check_b("rel_wdf_rdy", app_wdf_rdy, 1'b1);

        write_now(28'h5, D1, 16'hFFFF, "t1_wr");
        read_chk(28'h5, D1, "t1_rd");

        send_beat(128'hAA, 16'h0001, "t2_beat");
        check_b("t2_wdf_rdy_low", app_wdf_rdy, 1'b0);
        check_b("t2_app_rdy_high", app_rdy, 1'b1);
        repeat (2) tick();
        issue(3'b000, 28'h5, "t2_wr");
        check_b("t2_wdf_rdy_back", app_wdf_rdy, 1'b1);
        read_chk(28'h5, D2, "t2_rd");

        issue(3'b000, 28'h7, "t3_wr");
        for (int i = 0; i < 4; i++) begin
            check_b("t3_app_rdy_low", app_rdy, 1'b0);
            tick();
        end
        send_beat({16{8'h55}}, 16'hFFFF, "t3_beat");
        check_b("t3_app_rdy_back", app_rdy, 1'b1);
        read_chk(28'h7, {16{8'h55}}, "t3_rd");

        issue(3'b010, 28'h5, "t5_cmd");
        check_b("t5_app_rdy", app_rdy, 1'b1);
        repeat (4) tick();
        read_chk(28'h5, D2, "t5_rd");

        write_now(28'h000, D0, 16'hFFFF, "t6_wr0");
        write_now(28'h400, DX, 16'hFFFF, "t6_wr400");
        check_b("t6_oor_err", oor_err, OOR_EN);
        read_chk(28'h000, OOR_EN ? D0 : DX, "t6_rd0");
        read_chk(28'h400, OOR_EN ? 128'h0 : DX, "t6_rd400");

        write_now(28'h1, {16{8'h11}}, 16'hFFFF, "t4_wr1");
        write_now(28'h2, {16{8'h22}}, 16'hFFFF, "t4_wr2");
        write_now(28'h3, {16{8'h33}}, 16'hFFFF, "t4_wr3");
        fork
            begin
                issue(3'b001, 28'h1, "t4_rd1");
                issue(3'b001, 28'h2, "t4_rd2");
                issue(3'b001, 28'h3, "t4_rd3");
            end
            begin
                int got, t1;
                got = 0; t1 = 0;
                for (int n = 0; n < 12 && got < 2; n++) begin
                    @(negedge clk);
                    if (app_rd_data_valid) begin
                        if (got == 0) begin
                            check_w("t4_pulse1", app_rd_data, {16{8'h11}});
                            t1 = n;
                        end else begin
                            check_w("t4_pulse2", app_rd_data, {16{8'h22}});
                            check_i("t4_consecutive", n, t1 + 1);
                        end
                        got++;
                    end
                end
                check_i("t4_two_pulses", got, 2);
                #1 resetn = 1'b0;
            end
        join
        repeat (2) tick();
        resetn = 1'b1;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (app_rd_data_valid) cnt++;
        end
        check_i("t4_no_more_pulses", cnt, 0);
        check_b("t4_app_rdy_after_reset", app_rdy, 1'b1);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #100000;
        n_err++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule
